// File: rtl/cu_pkg.sv
// Shared types and constants for the CU stage sequencer and its helpers.
package cu_pkg;

   localparam int NUM_STAGES = 5;

   localparam int IF_IDX  = 0;
   localparam int ID_IDX  = 1;
   localparam int EX_IDX  = 2;
   localparam int MEM_IDX = 3;
   localparam int WB_IDX  = 4;

   typedef enum logic [1:0] {
      ST_RAMP   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_HALT_REQ = 2'b01,
      CAUSE_OVERRUN  = 2'b10,
      CAUSE_MISALIGN = 2'b11
   } halt_cause_e;

   // Front end (IF, ID) gets squashed on a redirect and frozen on a stall.
   localparam logic [NUM_STAGES-1:0] FRONT_MASK =
      NUM_STAGES'((1 << IF_IDX) | (1 << ID_IDX));
   // A stall injects its bubble into EX.
   localparam logic [NUM_STAGES-1:0] EX_MASK = NUM_STAGES'(1 << EX_IDX);

endpackage

// File: rtl/cu_pc_next.sv
// Next fetch address: redirect, sequential advance or hold, plus the
// overrun and misalignment flags used to stop the pipeline.
module cu_pc_next #(
   parameter int PC_STEP  = 4,
   parameter int PC_LIMIT = 512
) (
   input  logic [31:0] pc,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        advance,
   output logic [31:0] next_pc,
   output logic        overrun,
   output logic        misaligned
);

   localparam logic [32:0] STEP33  = 33'(PC_STEP);
   localparam logic [32:0] LIMIT33 = 33'(PC_LIMIT);

   logic [32:0] sum;

   // The 33-bit candidate keeps the carry so a wrap past 2^32 reads as overrun.
   always_comb begin
      sum = {1'b0, pc};
      if (branch_taken) begin
         sum = {1'b0, branch_target};
      end else if (advance) begin
         sum = {1'b0, pc} + STEP33;
      end
      next_pc    = sum[31:0];
      overrun    = (sum >= LIMIT33);
      misaligned = branch_taken & (branch_target[1:0] != 2'b00);
   end

endmodule

// File: rtl/cu_stage_sequencer.sv
// Slot-level controller for the five-stage CU datapath: phase counter,
// power-on ramp, per-stage strobes, PC ownership and drain-to-halt.
module cu_stage_sequencer
   import cu_pkg::*;
#(
   parameter int PHASES   = 4,
   parameter int PC_STEP  = 4,
   parameter int PC_LIMIT = 512
) (
   input  logic                      soc_clk,
   input  logic                      poweron,
   input  logic                      hazard_stall,
   input  logic                      branch_taken,
   input  logic [31:0]               branch_target,
   input  logic                      halt_req,
   output logic [$clog2(PHASES)-1:0] phase,
   output logic [NUM_STAGES-1:0]     stage_en,
   output logic [NUM_STAGES-1:0]     stage_fire,
   output logic [NUM_STAGES-1:0]     stage_stall,
   output logic [NUM_STAGES-1:0]     stage_flush,
   output logic [31:0]               pc,
   output logic                      halted,
   output logic [1:0]                halt_cause
);

   localparam int            PW         = $clog2(PHASES);
   localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);

   seq_state_e            state, state_nxt;
   halt_cause_e           cause, cause_nxt;
   logic [NUM_STAGES-1:0] en_nxt, stall_nxt, flush_nxt;
   logic [31:0]           pc_nxt, pc_cand;
   logic                  halted_nxt;
   logic                  slot_end, advance, overrun, misaligned, halt_now;

   assign slot_end   = (phase == LAST_PHASE);
   // A stalled front end refetches the same address.
   assign advance    = stage_en[IF_IDX] & ~hazard_stall;
   assign halt_now   = halt_req | overrun | misaligned;
   assign halt_cause = cause;

   cu_pc_next #(
      .PC_STEP  (PC_STEP),
      .PC_LIMIT (PC_LIMIT)
   ) u_pc_next (
      .pc            (pc),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .advance       (advance),
      .next_pc       (pc_cand),
      .overrun       (overrun),
      .misaligned    (misaligned)
   );

   // Free-running phase counter; only poweron restarts it.
   always_ff @(posedge soc_clk) begin
      if (!poweron) begin
         phase <= LAST_PHASE;
      end else begin
         phase <= phase + 1'b1;
      end
   end

   // State register and slot-scoped strobes; every field returns to reset.
   always_ff @(posedge soc_clk) begin
      if (!poweron) begin
         state       <= ST_RAMP;
         stage_en    <= '0;
         stage_stall <= '0;
         stage_flush <= '0;
         pc          <= '0;
         halted      <= 1'b0;
         cause       <= CAUSE_NONE;
      end else begin
         state       <= state_nxt;
         stage_en    <= en_nxt;
         stage_stall <= stall_nxt;
         stage_flush <= flush_nxt;
         pc          <= pc_nxt;
         halted      <= halted_nxt;
         cause       <= cause_nxt;
      end
   end

   // Slot-end decisions: halt beats branch beats stall beats normal advance.
   always_comb begin
      state_nxt  = state;
      en_nxt     = stage_en;
      stall_nxt  = stage_stall;
      flush_nxt  = stage_flush;
      pc_nxt     = pc;
      halted_nxt = halted;
      cause_nxt  = cause;
      if (slot_end) begin
         case (state)
            ST_RAMP, ST_RUN: begin
               stall_nxt = '0;
               flush_nxt = '0;
               if (halt_now) begin
                  // Abandon any remaining ramp and start emptying at once.
                  state_nxt = ST_DRAIN;
                  en_nxt    = {stage_en[WB_IDX-1:0], 1'b0};
                  if (halt_req) begin
                     cause_nxt = CAUSE_HALT_REQ;
                  end else if (overrun) begin
                     cause_nxt = CAUSE_OVERRUN;
                  end else begin
                     cause_nxt = CAUSE_MISALIGN;
                  end
                  if (en_nxt == '0) begin
                     state_nxt  = ST_HALTED;
                     halted_nxt = 1'b1;
                  end
               end else begin
                  pc_nxt = pc_cand;
                  if (state == ST_RAMP) begin
                     en_nxt = {stage_en[WB_IDX-1:0], 1'b1};
                     if (en_nxt == '1) begin
                        state_nxt = ST_RUN;
                     end
                  end
                  if (branch_taken) begin
                     flush_nxt = FRONT_MASK;
                  end else if (hazard_stall) begin
                     stall_nxt = FRONT_MASK;
                     flush_nxt = EX_MASK;
                  end
               end
            end
            ST_DRAIN: begin
               stall_nxt = '0;
               flush_nxt = '0;
               en_nxt    = {stage_en[WB_IDX-1:0], 1'b0};
               if (en_nxt == '0) begin
                  state_nxt  = ST_HALTED;
                  halted_nxt = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // A live, unstalled stage commits on the last phase of its slot.
   always_comb begin
      stage_fire = '0;
      if (slot_end) begin
         stage_fire = stage_en & ~stage_stall;
      end
   end

endmodule

// File: tb/tb_cu_stage_sequencer.sv
// Scoreboard bench for cu_stage_sequencer: two instances (normal and small
// PC limit) share stimulus; a slot-level reference model predicts each slot.
module tb_cu_stage_sequencer;

   localparam int PHASES = 4;

   logic        soc_clk = 1'b0;
   logic        poweron = 1'b0;
   logic        hazard_stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic        halt_req = 1'b0;
   logic [31:0] branch_target = '0;

   logic [1:0]  ph0, ph1;
   logic [4:0]  en0, fi0, st0, fl0, en1, fi1, st1, fl1;
   logic [31:0] pc0, pc1;
   logic        h0, h1;
   logic [1:0]  c0, c1;

   always #5 soc_clk = ~soc_clk;

   cu_stage_sequencer #(.PHASES(PHASES), .PC_STEP(4), .PC_LIMIT(512)) u_dut0 (
      .soc_clk(soc_clk), .poweron(poweron), .hazard_stall(hazard_stall),
      .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
      .phase(ph0), .stage_en(en0), .stage_fire(fi0), .stage_stall(st0),
      .stage_flush(fl0), .pc(pc0), .halted(h0), .halt_cause(c0));

   cu_stage_sequencer #(.PHASES(PHASES), .PC_STEP(4), .PC_LIMIT(32)) u_dut1 (
      .soc_clk(soc_clk), .poweron(poweron), .hazard_stall(hazard_stall),
      .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
      .phase(ph1), .stage_en(en1), .stage_fire(fi1), .stage_stall(st1),
      .stage_flush(fl1), .pc(pc1), .halted(h1), .halt_cause(c1));

   typedef struct {
      logic [4:0]  en, stall, flush;
      logic [31:0] pc;
      logic        halted;
      logic [1:0]  cause;
   } slot_t;

   typedef struct {
      logic [1:0]  phase;
      logic [4:0]  en, fire, stall, flush;
      logic [31:0] pc;
      logic        halted;
      logic [1:0]  cause;
   } obs_t;

   slot_t q0[$];
   slot_t q1[$];
   slot_t cur[2];
   bit    cur_valid[2];

   int checks = 0;
   int errors = 0;
   int m_phase = PHASES - 1;
   bit mon_active = 1'b0;

   // Reference model: live stages are the contiguous range [lo, hi).
   int          m_lo[2], m_hi[2];
   logic [31:0] m_pc[2];
   logic [4:0]  m_stall[2], m_flush[2];
   bit          m_drain[2], m_halted[2];
   logic [1:0]  m_cause[2];

   bit          r_hr, r_bt, r_hz;
   logic [31:0] r_tgt;

   function automatic longint limit_of(int d);
      return (d == 0) ? 64'd512 : 64'd32;
   endfunction

   function automatic logic [4:0] live_mask(int lo, int hi);
      logic [4:0] m = '0;
      for (int i = 0; i < 5; i++) if (i >= lo && i < hi) m[i] = 1'b1;
      return m;
   endfunction

   function automatic obs_t observe(int d);
      obs_t o;
      if (d == 0) begin
         o.phase = ph0; o.en = en0; o.fire = fi0; o.stall = st0; o.flush = fl0;
         o.pc = pc0; o.halted = h0; o.cause = c0;
      end else begin
         o.phase = ph1; o.en = en1; o.fire = fi1; o.stall = st1; o.flush = fl1;
         o.pc = pc1; o.halted = h1; o.cause = c1;
      end
      return o;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_lo[d] = 0; m_hi[d] = 0; m_pc[d] = '0;
         m_stall[d] = '0; m_flush[d] = '0;
         m_drain[d] = 1'b0; m_halted[d] = 1'b0; m_cause[d] = 2'd0;
      end
   endtask

   // Predict the slot that begins at the coming slot-end edge.
   task automatic model_step(int d, bit hr, bit bt, logic [31:0] tgt, bit hz);
      longint     cand;
      logic [1:0] why;
      slot_t      s;
      if (m_halted[d]) begin
      end else if (m_drain[d]) begin
         m_lo[d]++;
         if (m_hi[d] < 5) m_hi[d]++;
         if (m_lo[d] >= m_hi[d]) begin m_halted[d] = 1'b1; m_drain[d] = 1'b0; end
      end else begin
         if (bt) cand = {32'h0, tgt};
         else if (!hz && m_lo[d] == 0 && m_hi[d] > 0) cand = {32'h0, m_pc[d]} + 64'd4;
         else cand = {32'h0, m_pc[d]};
         why = 2'd0;
         if (hr) why = 2'd1;
         else if (cand >= limit_of(d)) why = 2'd2;
         else if (bt && tgt[1:0] != 2'b00) why = 2'd3;
         m_stall[d] = '0;
         m_flush[d] = '0;
         if (why != 2'd0) begin
            m_cause[d] = why;
            m_drain[d] = 1'b1;
            m_lo[d]++;
            if (m_hi[d] < 5) m_hi[d]++;
            if (m_lo[d] >= m_hi[d]) begin m_halted[d] = 1'b1; m_drain[d] = 1'b0; end
         end else begin
            if (m_hi[d] < 5) m_hi[d]++;
            m_pc[d] = cand[31:0];
            if (bt) m_flush[d] = 5'b00011;
            else if (hz) begin m_stall[d] = 5'b00011; m_flush[d] = 5'b00100; end
         end
      end
      s.en     = m_halted[d] ? 5'b0 : live_mask(m_lo[d], m_hi[d]);
      s.stall  = m_stall[d];
      s.flush  = m_flush[d];
      s.pc     = m_pc[d];
      s.halted = m_halted[d];
      s.cause  = m_cause[d];
      if (d == 0) q0.push_back(s);
      else q1.push_back(s);
   endtask

   // One clock: apply inputs, predict if the next edge ends a slot, step.
   task automatic drive_cycle(bit hr, bit bt, logic [31:0] tgt, bit hz);
      halt_req = hr; branch_taken = bt; branch_target = tgt; hazard_stall = hz;
      if (poweron && m_phase == PHASES - 1) begin
         model_step(0, hr, bt, tgt, hz);
         model_step(1, hr, bt, tgt, hz);
      end
      @(posedge soc_clk);
      #2;
      if (poweron) m_phase = (m_phase + 1) % PHASES;
      else m_phase = PHASES - 1;
   endtask

   task automatic noise();
      drive_cycle(1'($urandom), 1'($urandom), $urandom, 1'($urandom));
   endtask

   // Called at a slot start: junk inputs mid-slot, real inputs at slot end.
   task automatic slot(bit hr, bit bt, logic [31:0] tgt, bit hz);
      repeat (PHASES - 1) noise();
      drive_cycle(hr, bt, tgt, hz);
   endtask

   task automatic do_reset(int n);
      obs_t o;
      mon_active = 1'b0;
      poweron = 1'b0;
      q0.delete();
      q1.delete();
      repeat (n) noise();
      for (int d = 0; d < 2; d++) begin
         o = observe(d);
         chk($sformatf("dut%0d reset phase", d), o.phase, PHASES - 1);
         chk($sformatf("dut%0d reset en", d), o.en, 0);
         chk($sformatf("dut%0d reset fire", d), o.fire, 0);
         chk($sformatf("dut%0d reset stall", d), o.stall, 0);
         chk($sformatf("dut%0d reset flush", d), o.flush, 0);
         chk($sformatf("dut%0d reset pc", d), o.pc, 0);
         chk($sformatf("dut%0d reset halted", d), o.halted, 0);
         chk($sformatf("dut%0d reset cause", d), o.cause, 0);
      end
      model_reset();
      cur_valid[0] = 1'b0;
      cur_valid[1] = 1'b0;
      poweron = 1'b1;
      mon_active = 1'b1;
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   // Monitor: a new expected slot is popped whenever a DUT shows phase 0.
   always @(negedge soc_clk) begin
      if (mon_active) begin
         for (int d = 0; d < 2; d++) begin
            obs_t  o;
            slot_t s;
            o = observe(d);
            chk($sformatf("dut%0d phase", d), o.phase, m_phase);
            if (o.phase == 2'd0) begin
               if (d == 0 && q0.size() > 0) begin
                  cur[0] = q0.pop_front(); cur_valid[0] = 1'b1;
               end else if (d == 1 && q1.size() > 0) begin
                  cur[1] = q1.pop_front(); cur_valid[1] = 1'b1;
               end else begin
                  checks++;
                  errors++;
                  cur_valid[d] = 1'b0;
                  $display("FAIL dut%0d slot_entry: got 0 expected entries, required 1", d);
               end
            end
            if (cur_valid[d]) begin
               s = cur[d];
               chk($sformatf("dut%0d stage_en", d), o.en, s.en);
               chk($sformatf("dut%0d stage_stall", d), o.stall, s.stall);
               chk($sformatf("dut%0d stage_flush", d), o.flush, s.flush);
               chk($sformatf("dut%0d pc", d), o.pc, s.pc);
               chk($sformatf("dut%0d halted", d), o.halted, s.halted);
               chk($sformatf("dut%0d halt_cause", d), o.cause, s.cause);
               chk($sformatf("dut%0d stage_fire", d), o.fire,
                   (m_phase == PHASES - 1) ? (s.en & ~s.stall) : 5'd0);
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      // Run 1: ramp, overrun on the small-limit instance, branch, stall, halt.
      do_reset(3);
      chk("ramp_edge1_en", en0, 5'b00001);
      chk("ramp_edge1_pc", pc0, 0);
      slot(0, 0, 0, 0);
      chk("ramp_edge5_en", en0, 5'b00011);
      repeat (3) slot(0, 0, 0, 0);
      chk("ramp_edge17_en", en0, 5'b11111);
      chk("ramp_edge17_pc", pc0, 16);
      repeat (3) slot(0, 0, 0, 0);
      chk("limit32_pc28", pc1, 28);
      slot(0, 0, 0, 0);
      chk("limit32_cause", c1, 2'b10);
      chk("limit32_pc_frozen", pc1, 28);
      chk("limit512_pc32", pc0, 32);
      slot(0, 1, 32'h40, 0);
      chk("branch_pc", pc0, 32'h40);
      chk("branch_flush", fl0, 5'b00011);
      slot(0, 0, 0, 0);
      chk("after_branch_pc", pc0, 32'h44);
      slot(0, 0, 0, 1);
      chk("stall_pc_held", pc0, 32'h44);
      chk("stall_stall", st0, 5'b00011);
      chk("stall_flush", fl0, 5'b00100);
      slot(0, 1, 32'h80, 1);
      chk("stall_branch_pc", pc0, 32'h80);
      chk("stall_branch_stall", st0, 5'b00000);
      chk("limit32_halted", h1, 1'b1);
      slot(1, 0, 0, 0);
      chk("drain_first_en", en0, 5'b11110);
      repeat (4) slot(0, 0, 0, 0);
      chk("drain_done_en", en0, 5'b00000);
      chk("drain_halted", h0, 1'b1);
      chk("drain_cause", c0, 2'b01);
      chk("drain_pc_frozen", pc0, 32'h80);

      // Run 2: misaligned redirect, then reset in the middle of the drain.
      do_reset(2);
      repeat (4) slot(0, 0, 0, 0);
      slot(0, 1, 32'h42, 0);
      chk("misalign_cause", c0, 2'b11);
      chk("misalign_pc_frozen", pc0, 16);
      slot(0, 0, 0, 0);
      noise();
      noise();
      do_reset(1);
      repeat (4) slot(0, 0, 0, 0);
      chk("reramp_en", en0, 5'b11111);
      chk("reramp_pc", pc0, 16);

      // Run 3: randomized slots with occasional resets.
      for (int i = 0; i < 200; i++) begin
         if (m_halted[0] || $urandom_range(0, 39) == 0) begin
            repeat ($urandom_range(0, 2)) noise();
            do_reset(1 + $urandom_range(0, 1));
         end else begin
            r_hr  = ($urandom_range(0, 24) == 0);
            r_bt  = ($urandom_range(0, 3) == 0);
            r_hz  = ($urandom_range(0, 3) == 0);
            r_tgt = 32'($urandom_range(0, 150)) << 2;
            if ($urandom_range(0, 11) == 0) r_tgt[1:0] = 2'($urandom_range(1, 3));
            slot(r_hr, r_bt, r_tgt, r_hz);
         end
      end

      @(negedge soc_clk);
      #1;
      chk("scoreboard0_empty", q0.size(), 0);
      chk("scoreboard1_empty", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
